// File: rtl/adc_pkg.sv
// Shared types and frame constants for the preamp/ADC SPI reader.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AMP,
    ST_CONV,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int AMP_BITS       = 8;
  localparam int ADC_FRAME_BITS = 34;
  localparam int CH_A_FIRST     = 3;
  localparam int CH_B_FIRST     = 19;
  localparam int SAMPLE_W       = 14;
  localparam int PERIOD_W       = 6;

  // True when 1-based SCK rise number falls inside a channel's 14-bit window.
  function automatic logic in_window(input logic [PERIOD_W-1:0] rise, input int first);
    return (int'(rise) >= first) && (int'(rise) < first + SAMPLE_W);
  endfunction

endpackage

// File: rtl/sck_gen.sv
// SPI clock divider: SCK idles low, rises mid-period, counts completed periods.
module sck_gen #(
  parameter int CLK_DIV  = 2,
  parameter int PERIOD_W = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  output logic                sck,
  output logic                rise_stb,
  output logic                fall_stb,
  output logic [PERIOD_W-1:0] period_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             half_done;

  // Strobes mark the clock edge on which sck toggles.
  assign half_done = en && (div_cnt == DIV_LAST);
  assign rise_stb  = half_done && !sck;
  assign fall_stb  = half_done && sck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      sck        <= 1'b0;
      period_cnt <= '0;
    end else if (!en) begin
      div_cnt    <= '0;
      sck        <= 1'b0;
      period_cnt <= '0;
    end else begin
      div_cnt <= half_done ? '0 : div_cnt + 1'b1;
      if (half_done) sck <= !sck;
      if (fall_stb) period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master that programs the LTC6912 preamp and reads both LTC1407A channels
// on a free-running sample tick.
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 1134
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [3:0]                 gain_a,
  input  logic [3:0]                 gain_b,
  input  logic                       gain_load,
  input  logic                       bus_gnt,
  output logic                       bus_req,
  input  logic                       spi_miso,
  output logic                       spi_mosi,
  output logic                       spi_sck,
  output logic                       spi_amp_cs,
  output logic                       spi_adc_conv,
  output logic signed [SAMPLE_W-1:0] sample_a,
  output logic signed [SAMPLE_W-1:0] sample_b,
  output logic                       sample_valid,
  output logic                       overrun,
  output logic                       busy
);

  localparam int CNT_W = $clog2(18 * CLK_DIV + 1);
  localparam logic [CNT_W-1:0] AMP_LAST  = CNT_W'(18 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SCK_ON    = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] SCK_OFF   = CNT_W'(17 * CLK_DIV);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam int TMR_W = $clog2(SAMPLE_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [PERIOD_W-1:0] FRAME_LAST = PERIOD_W'(ADC_FRAME_BITS - 1);

  state_t              state;
  logic [CNT_W-1:0]    cyc_cnt;
  logic [TMR_W-1:0]    tmr;
  logic                tick;
  logic                gain_pend;
  logic                conv_pend;
  logic                amp_start;
  logic                conv_start;
  logic                mosi;
  logic                sck_en;
  logic                rise_stb;
  logic                fall_stb;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] rise_num;
  logic [AMP_BITS-1:0] gain_sr;
  logic [SAMPLE_W-1:0] shadow_a;
  logic [SAMPLE_W-1:0] shadow_b;

  assign tick       = (tmr == TMR_LAST);
  assign amp_start  = (state == ST_IDLE) && bus_gnt && gain_pend;
  assign conv_start = (state == ST_IDLE) && bus_gnt && !gain_pend && conv_pend;
  assign rise_num   = period_cnt + PERIOD_W'(1);
  assign spi_mosi   = mosi;

  // AMP frame: CLK_DIV of CS setup, 8 SCK periods, CLK_DIV of hold.
  assign sck_en = (state == ST_SHIFT) ||
                  ((state == ST_AMP) && (cyc_cnt >= SCK_ON) && (cyc_cnt < SCK_OFF));

  sck_gen #(
    .CLK_DIV  (CLK_DIV),
    .PERIOD_W (PERIOD_W)
  ) u_sck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (sck_en),
    .sck        (spi_sck),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .period_cnt (period_cnt)
  );

  // Shift registers hold no control meaning, so they carry no reset.
  always_ff @(posedge clk) begin
    if (amp_start)
      gain_sr <= {gain_b, gain_a};
    else if ((state == ST_AMP) && fall_stb)
      gain_sr <= {gain_sr[AMP_BITS-2:0], 1'b0};
    if ((state == ST_SHIFT) && rise_stb) begin
      if (in_window(rise_num, CH_A_FIRST)) shadow_a <= {shadow_a[SAMPLE_W-2:0], spi_miso};
      if (in_window(rise_num, CH_B_FIRST)) shadow_b <= {shadow_b[SAMPLE_W-2:0], spi_miso};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cyc_cnt      <= '0;
      tmr          <= '0;
      gain_pend    <= 1'b1;
      conv_pend    <= 1'b0;
      bus_req      <= 1'b0;
      busy         <= 1'b0;
      spi_amp_cs   <= 1'b1;
      spi_adc_conv <= 1'b0;
      mosi         <= 1'b0;
      sample_a     <= '0;
      sample_b     <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      tmr          <= tick ? '0 : tmr + 1'b1;
      sample_valid <= 1'b0;
      // A tick is only lost if the previous one is still waiting for the bus.
      overrun      <= tick && conv_pend && !conv_start;
      // Cleared at AMP entry so a load arriving mid-frame re-arms another frame.
      if (gain_load) gain_pend <= 1'b1;
      else if (amp_start) gain_pend <= 1'b0;
      if (tick) conv_pend <= 1'b1;
      else if (conv_start) conv_pend <= 1'b0;

      case (state)
        ST_IDLE: begin
          mosi    <= 1'b0;
          bus_req <= gain_pend | conv_pend;
          if (amp_start) begin
            state      <= ST_AMP;
            cyc_cnt    <= '0;
            spi_amp_cs <= 1'b0;
            mosi       <= gain_b[3];
            bus_req    <= 1'b1;
            busy       <= 1'b1;
          end else if (conv_start) begin
            state        <= ST_CONV;
            cyc_cnt      <= '0;
            spi_adc_conv <= 1'b1;
            bus_req      <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_AMP: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          if (fall_stb) mosi <= gain_sr[AMP_BITS-2];
          if (cyc_cnt == AMP_LAST) begin
            state      <= ST_IDLE;
            spi_amp_cs <= 1'b1;
            mosi       <= 1'b0;
            busy       <= 1'b0;
          end
        end
        ST_CONV: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          if (cyc_cnt == CONV_LAST) begin
            spi_adc_conv <= 1'b0;
            state        <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (fall_stb && (period_cnt == FRAME_LAST)) begin
            state        <= ST_DONE;
            sample_a     <= $signed(shadow_a);
            sample_b     <= $signed(shadow_b);
            sample_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          bus_req <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Randomized bench for adc_spi_reader with a frame-level ADC/preamp model.
module tb_adc_spi_reader;

  localparam int C1  = 2;
  localparam int SD1 = 300;
  localparam int C2  = 1;
  localparam int SD2 = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  gain_a = 4'h0, gain_b = 4'h0;
  logic        gain_load = 1'b0, bus_gnt = 1'b0, spi_miso = 1'b0;
  logic        bus_req, spi_mosi, spi_sck, spi_amp_cs, spi_adc_conv;
  logic [13:0] sample_a, sample_b;
  logic        sample_valid, overrun, busy;

  logic        rst2_n = 1'b0;
  logic        bus_req2, mosi2, sck2, amp_cs2, conv2, valid2, overrun2, busy2;
  logic [13:0] sample_a2, sample_b2;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, rel_edges = 0;

  always #5 clk = ~clk;

  adc_spi_reader #(.CLK_DIV(C1), .SAMPLE_DIV(SD1)) dut (
    .clk(clk), .reset_n(reset_n), .gain_a(gain_a), .gain_b(gain_b),
    .gain_load(gain_load), .bus_gnt(bus_gnt), .bus_req(bus_req),
    .spi_miso(spi_miso), .spi_mosi(spi_mosi), .spi_sck(spi_sck),
    .spi_amp_cs(spi_amp_cs), .spi_adc_conv(spi_adc_conv),
    .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid),
    .overrun(overrun), .busy(busy));

  adc_spi_reader #(.CLK_DIV(C2), .SAMPLE_DIV(SD2)) dut2 (
    .clk(clk), .reset_n(rst2_n), .gain_a(4'h3), .gain_b(4'h5),
    .gain_load(1'b0), .bus_gnt(1'b1), .bus_req(bus_req2),
    .spi_miso(1'b1), .spi_mosi(mosi2), .spi_sck(sck2),
    .spi_amp_cs(amp_cs2), .spi_adc_conv(conv2),
    .sample_a(sample_a2), .sample_b(sample_b2), .sample_valid(valid2),
    .overrun(overrun2), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) rel_edges = 0;
    else rel_edges++;
  end

  // ADC model: 34-bit frame = 2 junk, A, 2 junk, B, 2 junk, MSB first.
  logic [13:0] exp_a_q[$], exp_b_q[$];
  logic [13:0] force_a, force_b;
  logic        force_ab = 1'b0;
  logic [33:0] frame;
  int          bit_idx = 0;

  always @(posedge spi_adc_conv) begin
    logic [13:0] a, b;
    a = force_ab ? force_a : 14'($urandom);
    b = force_ab ? force_b : 14'($urandom);
    force_ab = 1'b0;
    frame = {2'($urandom), a, 2'($urandom), b, 2'($urandom)};
    exp_a_q.push_back(a);
    exp_b_q.push_back(b);
    bit_idx = 0;
    spi_miso = frame[33];
  end
  always @(posedge spi_sck) if (spi_amp_cs) bit_idx++;
  always @(negedge spi_sck) if (spi_amp_cs && bit_idx < 34) spi_miso = frame[33 - bit_idx];
  always @(negedge reset_n) begin
    exp_a_q.delete();
    exp_b_q.delete();
  end

  // Preamp frame observer: CS length and bits seen on MOSI at SCK rises.
  int         amp_run = 0, amp_frames = 0, last_amp_len = 0, amp_rises = 0, last_amp_rises = 0;
  int         amp_end_cyc = 0;
  logic [7:0] amp_word = 8'h0, last_amp_word = 8'h0;

  always @(posedge spi_sck) if (!spi_amp_cs) begin
    amp_word = {amp_word[6:0], spi_mosi};
    amp_rises++;
  end

  int conv_len = 0, conv_rise_cyc = 0, valid_cnt = 0, ov_cnt = 0, sck_rises = 0;
  logic conv_prev = 1'b0;

  always @(posedge spi_sck) sck_rises++;

  always @(negedge clk) if (reset_n) begin
    if (!spi_amp_cs) amp_run++;
    else if (amp_run != 0) begin
      last_amp_len = amp_run;
      last_amp_word = amp_word;
      last_amp_rises = amp_rises;
      amp_run = 0;
      amp_rises = 0;
      amp_end_cyc = cyc;
      amp_frames++;
    end
    if (spi_adc_conv && !conv_prev) conv_rise_cyc = cyc;
    if (spi_adc_conv) conv_len++;
    else if (conv_len != 0) begin
      check("conv_len", conv_len, 2 * C1);
      conv_len = 0;
    end
    conv_prev = spi_adc_conv;
    if (overrun) ov_cnt++;
    if (sample_valid) begin
      valid_cnt++;
      check("valid_latency", cyc - conv_rise_cyc, 70 * C1);
      if (exp_a_q.size() == 0) check("valid_unexpected", 1, 0);
      else begin
        check("sample_a", sample_a, exp_a_q.pop_front());
        check("sample_b", sample_b, exp_b_q.pop_front());
      end
    end
  end

  int last_v2 = -1, v2_cnt = 0, ov2_cnt = 0;
  always @(negedge clk) if (rst2_n) begin
    if (overrun2) ov2_cnt++;
    if (valid2) begin
      check("d2_sample_a", sample_a2, 14'h3FFF);
      check("d2_sample_b", sample_b2, 14'h3FFF);
      if (last_v2 >= 0) check("d2_period", cyc - last_v2, SD2);
      last_v2 = cyc;
      v2_cnt++;
    end
  end

  task automatic wait_amps(input int n, input int budget);
    for (int k = 0; k < budget && amp_frames < n; k++) @(negedge clk);
    if (amp_frames < n) check("amp_timeout", amp_frames, n);
  endtask

  task automatic wait_valids(input int n, input int budget);
    for (int k = 0; k < budget && valid_cnt < n; k++) @(negedge clk);
    if (valid_cnt < n) check("valid_timeout", valid_cnt, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sck"}, spi_sck, 0);
    check({tag, "_mosi"}, spi_mosi, 0);
    check({tag, "_amp_cs"}, spi_amp_cs, 1);
    check({tag, "_conv"}, spi_adc_conv, 0);
    check({tag, "_sample_a"}, sample_a, 0);
    check({tag, "_sample_b"}, sample_b, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int v0, ov0, r0, k;
    logic [3:0] ga, gb;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Power-up: preamp programmed first with gains 1/1.
    gain_a = 4'h1; gain_b = 4'h1; bus_gnt = 1'b1;
    reset_n = 1'b1; rst2_n = 1'b1;
    wait_amps(1, 200);
    check("amp_len", last_amp_len, 18 * C1);
    check("amp_word", last_amp_word, 8'h11);
    check("amp_rises", last_amp_rises, 8);

    // Directed sample values, then randomized frames.
    force_a = 14'h2ABC; force_b = 14'h3FFF; force_ab = 1'b1;
    wait_valids(1, 2 * SD1);
    @(negedge clk);
    check("valid_pulse", sample_valid, 0);
    wait_valids(valid_cnt + 3, 4 * SD1);

    // Bus withheld across two ticks: one overrun, one conversion after grant.
    bus_gnt = 1'b0; v0 = valid_cnt; ov0 = ov_cnt;
    repeat (500) @(negedge clk);
    check("overrun_cnt", ov_cnt - ov0, 1);
    check("no_conv_wo_gnt", valid_cnt - v0, 0);
    check("bus_req_pend", bus_req, 1);
    bus_gnt = 1'b1;
    repeat (200) @(negedge clk);
    check("one_conv_after_gnt", valid_cnt - v0, 1);

    // gain_load in the same cycle as a timer wrap.
    ga = 4'($urandom); gb = 4'($urandom);
    k = 0;
    while ((rel_edges % SD1) != SD1 - 1 && k < 2 * SD1) begin @(negedge clk); k++; end
    v0 = amp_frames;
    gain_a = ga; gain_b = gb; gain_load = 1'b1;
    @(negedge clk);
    gain_load = 1'b0;
    wait_amps(v0 + 1, 100);
    check("amp_word_new", last_amp_word, {gb, ga});
    wait_valids(valid_cnt + 1, 2 * SD1);
    check("amp_before_conv", amp_end_cyc < conv_rise_cyc, 1);

    // Async reset at SCK rise 10 of SHIFT.
    for (k = 0; k < 2 * SD1 && !spi_adc_conv; k++) @(negedge clk);
    check("conv_seen", spi_adc_conv, 1);
    check("busy_in_frame", busy, 1);
    check("bus_req_in_frame", bus_req, 1);
    r0 = sck_rises;
    for (k = 0; k < 200 && (sck_rises - r0) < 10; k++) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async");
    v0 = valid_cnt;
    ga = 4'($urandom); gb = 4'($urandom);
    gain_a = ga; gain_b = gb;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    r0 = amp_frames;
    wait_amps(r0 + 1, 100);
    check("reprog_word", last_amp_word, {gb, ga});
    check("reprog_len", last_amp_len, 18 * C1);
    check("no_valid_after_abort", valid_cnt, v0);
    wait_valids(v0 + 1, 2 * SD1);

    check("d2_overrun", ov2_cnt, 0);
    check("d2_valids", v2_cnt >= 10, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
